// File: rtl/work_pkg.sv
// rtl/work_pkg.sv - shared types and constants for the sprite line scheduler
package work_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ADDR,
    LOAD,
    NEXT
  } fetch_state_t;

  localparam int SPR_W  = 8;
  localparam int ROM_AW = 6;

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// rtl/sprite_line_scheduler_if.sv - shared sprite ROM bus, scheduler is master
interface sprite_line_scheduler_if;
  import work_pkg::*;

  logic [ROM_AW-1:0] rom_addr;
  logic [SPR_W-1:0]  rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_shifter.sv
// rtl/sprite_shifter.sv - per-sprite pending/active row buffer and 8-pixel shifter
module sprite_shifter
  import work_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       hpos,
  input  logic             pend_we,
  input  logic [SPR_W-1:0] pend_bits,
  input  logic [9:0]       pend_x,
  output logic             lit
);

  logic [SPR_W-1:0] pend_bits_q, act_bits, sh;
  logic [9:0]       pend_x_q, act_x;
  logic [SPR_W-1:0] cur_bits;
  logic [9:0]       cur_x;
  logic             start;

  // At hpos 0 the transfer is still in flight, so look through to pending
  always_comb begin
    cur_bits = (hpos == 10'd0) ? pend_bits_q : act_bits;
    cur_x    = (hpos == 10'd0) ? pend_x_q    : act_x;
    start    = (hpos == cur_x) && (cur_x < 10'(H_ACTIVE));
    lit      = (hpos < 10'(H_ACTIVE)) && (start ? cur_bits[SPR_W-1] : sh[SPR_W-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_bits_q <= '0;
      pend_x_q    <= '0;
      act_bits    <= '0;
      act_x       <= '0;
      sh          <= '0;
    end else begin
      if (pend_we) begin
        pend_bits_q <= pend_bits;
        pend_x_q    <= pend_x;
      end
      if (hpos == 10'd0) begin
        act_bits <= pend_bits_q;
        act_x    <= pend_x_q;
      end
      if (start) sh <= cur_bits << 1;
      else       sh <= sh << 1;
    end
  end

endmodule

// File: rtl/sprite_line_scheduler.sv
// rtl/sprite_line_scheduler.sv - fetches next-line sprite rows in blanking and draws them
// Optional collision output under SPRITE_COLLISION_EN.
module sprite_line_scheduler
  import work_pkg::*;
#(
  parameter int NSPR     = 4,
  parameter int SPR_H    = 16,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           hpos,
  input  logic [9:0]           vpos,
  input  logic [NSPR-1:0][9:0] spr_x,
  input  logic [NSPR-1:0][9:0] spr_y,
  input  logic [NSPR-1:0][1:0] spr_img,
  sprite_line_scheduler_if.master rom,
  output logic                 pix_on,
  output logic [1:0]           pix_id,
  output logic                 busy
`ifdef SPRITE_COLLISION_EN
  ,
  output logic [NSPR-1:0]      collision
`endif
);

  localparam int IW = (NSPR > 1) ? $clog2(NSPR) : 1;

  fetch_state_t      state, state_nx;
  logic [IW-1:0]     idx;
  logic [ROM_AW-1:0] rom_addr_q;
  logic [9:0]        nl, y_cur, row_lin, row_wrap;
  logic              lin_hit, wrap_hit, hit, last;
  logic [3:0]        row_lo;
  logic              pend_we, addr_load;
  logic [SPR_W-1:0]  pend_bits;
  logic [NSPR-1:0]   lit;
  logic [1:0]        win_id;

  // Rows past the bottom of the frame wrap back to the top via V_TOTAL
  always_comb begin
    nl       = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
    y_cur    = spr_y[idx];
    row_lin  = nl - y_cur;
    row_wrap = nl + 10'(V_TOTAL) - y_cur;
    lin_hit  = row_lin < 10'(SPR_H);
    wrap_hit = (nl < y_cur) && (y_cur < 10'(V_TOTAL)) && (row_wrap < 10'(SPR_H));
    hit      = lin_hit || wrap_hit;
    row_lo   = lin_hit ? row_lin[3:0] : row_wrap[3:0];
    last     = (idx == IW'(NSPR - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (hpos == 10'(H_ACTIVE)) state_nx = CHECK;
      CHECK: state_nx = hit ? ADDR : NEXT;
      ADDR:  state_nx = LOAD;
      LOAD:  state_nx = last ? IDLE : CHECK;
      NEXT:  state_nx = last ? IDLE : CHECK;
      default: state_nx = IDLE;
    endcase
  end

  // A miss writes a blank row so a stale image never survives a line
  always_comb begin
    busy      = (state != IDLE);
    addr_load = (state == CHECK) && hit;
    pend_we   = ((state == CHECK) && !hit) || (state == LOAD);
    pend_bits = (state == LOAD) ? rom.rom_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      rom_addr_q <= '0;
    end else begin
      if (state == LOAD || state == NEXT) idx <= last ? '0 : idx + 1'b1;
      if (addr_load) rom_addr_q <= {spr_img[idx], row_lo};
    end
  end

  assign rom.rom_addr = rom_addr_q;

  for (genvar g = 0; g < NSPR; g++) begin : g_spr
    sprite_shifter #(.H_ACTIVE(H_ACTIVE)) u_shifter (
      .clk       (clk),
      .reset     (reset),
      .hpos      (hpos),
      .pend_we   (pend_we && (idx == IW'(g))),
      .pend_bits (pend_bits),
      .pend_x    (spr_x[idx]),
      .lit       (lit[g])
    );
  end

  always_comb begin
    win_id = 2'd0;
    for (int k = NSPR - 1; k >= 0; k--)
      if (lit[k]) win_id = 2'(k);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_on <= 1'b0;
      pix_id <= 2'd0;
    end else begin
      pix_on <= |lit;
      pix_id <= win_id;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [NSPR-1:0] col_now;

  always_comb begin
    col_now = '0;
    for (int k = 0; k < NSPR; k++)
      col_now[k] = lit[k] && |(lit & ~(NSPR'(1) << k));
  end

  always_ff @(posedge clk) begin
    if (reset) collision <= '0;
    else collision <= (((hpos == 10'd0) && (vpos == 10'd0)) ? '0 : collision) | col_now;
  end
`else
  // collision tracking not built
`endif

endmodule

// File: doc/sprite_line_scheduler.md
SPRITE_LINE_SCHEDULER -- requirements
Module: sprite_line_scheduler

Interface
REQ-001 Parameter NSPR, default 4: number of hardware sprites.
REQ-002 Parameter SPR_H, default 16: sprite height in lines (power of two).
REQ-003 Parameter H_ACTIVE, default 640: first hpos of horizontal blanking.
REQ-004 Parameter V_TOTAL, default 525: lines per frame; vpos wraps V_TOTAL-1 -> 0.
REQ-005 clk  in  1: pixel clock (the divided pixel clock, one pixel per cycle).
REQ-006 reset  in  1: synchronous, active-high reset.
REQ-007 hpos  in  10: current horizontal pixel counter.
REQ-008 vpos  in  10: current line counter.
REQ-009 spr_x  in  NSPR x 10: sprite left column.
REQ-010 spr_y  in  NSPR x 10: sprite top line.
REQ-011 spr_img  in  NSPR x 2: image select into shared ROM.
REQ-012 rom_addr  out  6: shared sprite ROM address {img[1:0], row[3:0]}.
REQ-013 rom_data  in  8: ROM row bits, valid exactly one cycle after rom_addr; MSB is leftmost pixel.
REQ-014 pix_on  out  1: a sprite pixel is lit at the current hpos.
REQ-015 pix_id  out  2: index of the winning sprite when pix_on=1, else 0.
REQ-016 busy  out  1: fetch FSM not in IDLE.

Function
REQ-017 Fetch FSM states SHALL be IDLE, CHECK, ADDR, LOAD, NEXT; leave IDLE only when hpos==H_ACTIVE.
REQ-018 Target line nl SHALL be vpos+1, or 0 when vpos==V_TOTAL-1.
REQ-019 CHECK SHALL compute row = nl - spr_y[i] (10-bit unsigned, modulo 1024); hit iff row < SPR_H; miss -> NEXT with sprite i's line buffer cleared to 0.
REQ-020 ADDR SHALL drive rom_addr={spr_img[i], row[3:0]}; LOAD SHALL capture rom_data into pending buffer i and latch spr_x[i].
REQ-021 NEXT SHALL increment i; after i==NSPR-1 return to IDLE, with i reset to 0.
REQ-022 Worst-case fetch SHALL be 3*NSPR cycles (12 at default) and complete inside blanking.
REQ-023 Pending buffers SHALL transfer to active shifters at hpos==0 of the next line, never mid-line.
REQ-024 Sprite i SHALL load its 8-bit shifter when hpos==latched x, output MSB, and shift left once per cycle for 8 pixels, then output 0.
REQ-025 pix_on/pix_id SHALL be registered, one cycle after the hpos they describe.
REQ-026 Overlap: lowest sprite index wins pix_id.
REQ-027 x >= H_ACTIVE: sprite never drawn. Partial right clipping at H_ACTIVE is permitted.
REQ-028 The row-compute wrap SHALL let a sprite with spr_y > V_TOTAL-SPR_H appear partially at top of frame.

Reset
REQ-029 Reset SHALL force IDLE, i=0, rom_addr=0, busy=0, pix_on=0, pix_id=0, and clear all pending and active buffers.
REQ-030 Reset asserted mid-fetch SHALL abort; no sprite is drawn on the following line.

Configuration
REQ-031 SPRITE_COLLISION_EN defined: add output collision (NSPR bits). Bit i is set sticky when sprite i is lit together with any other sprite on the same pixel, and cleared at hpos==0 && vpos==0.
REQ-032 SPRITE_COLLISION_EN undefined: no collision port and no collision logic.

Structure
REQ-033 The shared package work_pkg SHALL hold the FSM state enum, the constant SPR_W=8, and the ROM address width.
REQ-034 One sub-module, sprite_shifter, SHALL be instantiated NSPR times. It holds pending/active buffers, x compare and 8-pixel shift.

Verification
REQ-035 Scenario 1: sprite0 y=100, x=200, ROM row0=8'hA5; at vpos=99 fetch, at vpos=100 -> pix_on pattern 1,0,1,0,0,1,0,1 at hpos 200..207 (+1 cycle).
REQ-036 Scenario 2: sprite1 and sprite2 overlap at x=300 on the same line -> pix_id=1 on the shared lit pixels.
REQ-037 Scenario 3: sprite3 y=520, vpos=524 -> rom_addr row=5, sprite3 drawn on line 0.
REQ-038 Scenario 4: all sprites miss -> busy high exactly 2*NSPR cycles (8 at default), pix_on stays 0.
REQ-039 Scenario 5: reset pulsed at hpos=H_ACTIVE+4 -> busy=0 next cycle, no pixels on the next line.
REQ-040 Scenario 6 (SPRITE_COLLISION_EN): sprites 0/1 overlap once -> collision=4'b0011, cleared at frame start.
